decode_dispatch: RTL

//  Front-end stage directly upstream of issue_queue.
//  - Accepts up to two fetched MIPS words per cycle.
//  - Decodes each one into an ISSUE_QUEUE_ELEMENT.
//  - Buffers the decoded entries in a small in-order FIFO.
//  - Pushes 0..2 entries per cycle into issue_queue (in_data / in_data_number).
//  - Push count is limited by the queue's size_left, so no entry is lost when the queue backs up.

---
 rtl/decode_dispatch_pkg.sv | 86 ++++++++
 rtl/decode_dispatch_inst_decoder.sv | 115 +++++++++++
 rtl/decode_dispatch.sv | 91 +++++++++
 3 files changed

// File: rtl/decode_dispatch_pkg.sv
// Shared decode types: issue-queue entry layout, MIPS opcode/funct encodings, op classes.
// Used by decode, issue and execute.
package decode_dispatch_pkg;

    localparam int IQ_ADDR  = 4;
    localparam int REG_ADDR = 5;

    typedef logic bool;

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00,
        OP_J       = 6'h02,
        OP_JAL     = 6'h03,
        OP_BEQ     = 6'h04,
        OP_BNE     = 6'h05,
        OP_ADDI    = 6'h08,
        OP_ADDIU   = 6'h09,
        OP_SLTI    = 6'h0A,
        OP_SLTIU   = 6'h0B,
        OP_ANDI    = 6'h0C,
        OP_ORI     = 6'h0D,
        OP_XORI    = 6'h0E,
        OP_LUI     = 6'h0F,
        OP_LW      = 6'h23,
        OP_SW      = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_SRA  = 6'h03,
        FN_JR   = 6'h08,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_t;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_ALU,
        CLS_SHIFT,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP
    } op_class_t;

    typedef enum logic [3:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_LUI
    } alu_op_t;

    typedef struct packed {
        op_class_t             op_class;
        alu_op_t               alu_op;
        bool                   rs_en;
        bool                   rt_en;
        bool                   dest_en;
        bool                   reserved;
        logic [REG_ADDR-1:0]   rs;
        logic [REG_ADDR-1:0]   rt;
        logic [REG_ADDR-1:0]   dest;
        logic [4:0]            shamt;
        logic [31:0]           imm;
        logic [31:0]           pc;
    } issue_queue_element_t;

endpackage

// File: rtl/decode_dispatch_inst_decoder.sv
// Combinational MIPS decoder: one raw word plus its PC into an issue-queue entry.
// Unknown encodings are flagged reserved and carry no register enables.
module decode_dispatch_inst_decoder
    import decode_dispatch_pkg::*;
(
    input  logic [31:0]          inst,
    input  logic [31:0]          pc,
    output issue_queue_element_t entry
);

    logic [REG_ADDR-1:0] dest;
    logic                wen;

    always_comb begin
        entry          = '0;
        entry.pc       = pc;
        entry.rs       = inst[25:21];
        entry.rt       = inst[20:16];
        entry.shamt    = inst[10:6];
        entry.imm      = {{16{inst[15]}}, inst[15:0]};
        entry.op_class = CLS_NONE;
        entry.alu_op   = ALU_NONE;
        dest           = inst[20:16];
        wen            = 1'b0;
        unique case (opcode_t'(inst[31:26]))
            OP_SPECIAL: begin
                entry.op_class = CLS_ALU;
                entry.rs_en    = 1'b1;
                entry.rt_en    = 1'b1;
                dest           = inst[15:11];
                wen            = 1'b1;
                unique case (funct_t'(inst[5:0]))
                    FN_ADD, FN_ADDU: entry.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: entry.alu_op = ALU_SUB;
                    FN_AND:          entry.alu_op = ALU_AND;
                    FN_OR:           entry.alu_op = ALU_OR;
                    FN_XOR:          entry.alu_op = ALU_XOR;
                    FN_NOR:          entry.alu_op = ALU_NOR;
                    FN_SLT:          entry.alu_op = ALU_SLT;
                    FN_SLTU:         entry.alu_op = ALU_SLTU;
                    FN_SLL, FN_SRL, FN_SRA: begin
                        entry.op_class = CLS_SHIFT;
                        entry.rs_en    = 1'b0;
                        entry.alu_op   = (inst[5:0] == FN_SLL) ? ALU_SLL :
                                         (inst[5:0] == FN_SRL) ? ALU_SRL : ALU_SRA;
                    end
                    FN_JR: begin
                        entry.op_class = CLS_JUMP;
                        entry.rt_en    = 1'b0;
                        wen            = 1'b0;
                    end
                    default: begin
                        entry.op_class = CLS_NONE;
                        entry.reserved = 1'b1;
                        entry.rs_en    = 1'b0;
                        entry.rt_en    = 1'b0;
                        wen            = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                entry.op_class = CLS_ALU;
                entry.rs_en    = 1'b1;
                wen            = 1'b1;
                entry.alu_op   = (inst[31:26] == OP_SLTI)  ? ALU_SLT  :
                                 (inst[31:26] == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
            end
            // logical immediates are zero-extended
            OP_ANDI, OP_ORI, OP_XORI: begin
                entry.op_class = CLS_ALU;
                entry.rs_en    = 1'b1;
                wen            = 1'b1;
                entry.imm      = {16'h0000, inst[15:0]};
                entry.alu_op   = (inst[31:26] == OP_ANDI) ? ALU_AND :
                                 (inst[31:26] == OP_ORI)  ? ALU_OR  : ALU_XOR;
            end
            OP_LUI: begin
                entry.op_class = CLS_ALU;
                entry.alu_op   = ALU_LUI;
                entry.imm      = {16'h0000, inst[15:0]};
                wen            = 1'b1;
            end
            OP_LW: begin
                entry.op_class = CLS_LOAD;
                entry.alu_op   = ALU_ADD;
                entry.rs_en    = 1'b1;
                wen            = 1'b1;
            end
            OP_SW: begin
                entry.op_class = CLS_STORE;
                entry.alu_op   = ALU_ADD;
                entry.rs_en    = 1'b1;
                entry.rt_en    = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                entry.op_class = CLS_BRANCH;
                entry.alu_op   = ALU_SUB;
                entry.rs_en    = 1'b1;
                entry.rt_en    = 1'b1;
            end
            OP_J, OP_JAL: begin
                entry.op_class = CLS_JUMP;
                entry.imm      = {6'b0, inst[25:0]};
                dest           = 5'd31;
                wen            = (inst[31:26] == OP_JAL);
            end
            default: begin
                entry.reserved = 1'b1;
            end
        endcase
        entry.dest    = wen ? dest : '0;
        entry.dest_en = wen & (dest != '0);
    end

endmodule

// File: rtl/decode_dispatch.sv
// Two-wide decode stage feeding issue_queue through a small in-order FIFO.
// Dispatch count is bounded by buffered entries and the queue's free space.
module decode_dispatch
    import decode_dispatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [WIDTH-1:0]                fetch_valid,
    input  logic [WIDTH-1:0][31:0]          fetch_inst,
    input  logic [WIDTH-1:0][31:0]          fetch_pc,
    output logic                            fetch_ready,
    input  logic [IQ_ADDR-1:0]              iq_size_left,
    output issue_queue_element_t [WIDTH-1:0] in_data,
    output logic [1:0]                      in_data_number
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    issue_queue_element_t            mem [DEPTH];
    issue_queue_element_t [WIDTH-1:0] dec;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic [1:0]    n_in;
    logic [1:0]    n_out;

    for (genvar i = 0; i < WIDTH; i++) begin : g_dec
        decode_dispatch_inst_decoder u_dec (
            .inst  (fetch_inst[i]),
            .pc    (fetch_pc[i]),
            .entry (dec[i])
        );
    end

    always_comb begin
        free        = CW'(DEPTH) - count;
        fetch_ready = rst & ~flush & (free >= CW'(2));
        n_in        = 2'd0;
        if (fetch_ready) begin
            unique case (fetch_valid)
                2'b01:   n_in = 2'd1;
                2'b11:   n_in = 2'd2;
                default: n_in = 2'd0;
            endcase
        end
    end

    always_comb begin
        n_out = 2'd2;
        if (count < CW'(2))
            n_out = count[1:0];
        if (iq_size_left < IQ_ADDR'(n_out))
            n_out = iq_size_left[1:0];
        if (!rst || flush)
            n_out = 2'd0;
        in_data_number = n_out;
        in_data        = '0;
        if (n_out != 2'd0)
            in_data[0] = mem[rd_ptr];
        if (n_out == 2'd2)
            in_data[1] = mem[rd_ptr + AW'(1)];
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_in);
            rd_ptr <= rd_ptr + AW'(n_out);
            count  <= count + CW'(n_in) - CW'(n_out);
        end
    end

    // entries need no reset; count alone decides what is valid
    always_ff @(posedge clk) begin
        if (n_in != 2'd0)
            mem[wr_ptr] <= dec[0];
        if (n_in == 2'd2)
            mem[wr_ptr + AW'(1)] <= dec[1];
    end

endmodule
